key_event_gen: RTL and testbench
================================

// Module: key_event_gen
// PURPOSE
//  Producer side of the keycode interface: turns raw USB-HID keyboard reports into the
//  registered keycode bus the game FSM reads. Also emits one-cycle key events.
//  Sits between the USB/HID host interface and the game-state and piece-control logic.
//  Events are press edges plus frame-paced delayed auto-shift (DAS) repeats.
// PARAMETERS
//  DAS_FRAMES  16        frame_ticks from press to first auto-repeat (>=1)
//  ARR_FRAMES  6         frame_ticks between subsequent auto-repeats (>=1)
//  REPEAT_MASK 6'b000111 per-key repeat enable, bit index = key_idx_e (L,R,Down repeat)
// PORTS
//  Clk          in   1   system clock; single clock domain
//  Reset_n      in   1   asynchronous, active-low reset
//  raw_keycode  in   16  HID report: two key slots [7:0] and [15:8], 8'h00 = no key
//  frame_tick   in   1   one-cycle pulse per video frame (vsync-derived, same Clk domain)
//  gamestate    in   2   1=Idle 2=Game 3=End; repeats only in Game
//  keycode      out  16  registered copy of raw_keycode for the game FSM
//  key_held     out  6   level: key currently present in either slot
//  key_evt      out  6   one-cycle pulse: press edge or auto-repeat
// BEHAVIOUR
//  - Key map (key_idx_e / HID code): 0 LEFT 8'h50, 1 RIGHT 8'h4F, 2 DOWN 8'h51,
//    3 ROTATE(Up) 8'h52, 4 DROP(Space) 8'h2C, 5 ENTER 8'h28.
//  - Held decode: held[k] = (slot0==code[k]) | (slot1==code[k]). key_held is a register.
//  - keycode and key_held update 1 cycle after raw_keycode changes.
//  - Press: key_evt[k] pulses for exactly 1 cycle, in the same cycle key_held[k] first reads 1.
//    Same-key repeat in both slots counts as one key. Release generates no event.
//  - Per repeatable key: counter of width $clog2(max(DAS,ARR)+1), saturating, never wraps.
//    * Press edge: load DAS_FRAMES. A frame_tick in the same cycle is ignored for that key.
//    * While held and gamestate==2: decrement on each frame_tick.
//      A frame_tick with count==1 pulses key_evt[k] and reloads ARR_FRAMES.
//    * First repeat lands on the DAS_FRAMES-th tick after press. ARR_FRAMES=1 repeats every tick.
//    * Release, or gamestate!=2: counter holds 0 and no repeats are issued.
//      Re-entering Game while held does not restart DAS; only a new press does.
//  - LEFT and RIGHT held together: both press pulses still issue. Both L/R repeat
//    counters are forced to 0 while both are held. Releasing one does not resume repeats
//    for the other until that key is re-pressed.
//  - Press and repeat pulses never stack: at most one key_evt[k] pulse per cycle.
//  - Reset (async assert, any time incl. mid-repeat): keycode=16'h0, key_held=0, key_evt=0,
//    counters=0, prev-held=0. A key held across reset deassert produces one press edge.
// CONFIGURATION
//  - KEYGEN_SYNC_EN defined: raw_keycode passes through a 2-flop register stage before decode.
//    All keycode/key_held/key_evt latencies grow by 2 cycles (total 3). frame_tick is not delayed.
//  - KEYGEN_SYNC_EN undefined: raw_keycode is decoded directly with 1-cycle latency.
// STRUCTURE
//  - Package tetris_pkg: key_idx_e enum, NUM_KEYS=6, HID code localparams (HID_LEFT..HID_ENTER),
//    gamestate encodings (GS_IDLE=2'd1, GS_GAME=2'd2, GS_END=2'd3).
//  - Sub-module key_repeat_ctr: one DAS/ARR counter, generated for each REPEAT_MASK bit.
//    Ports: Clk, Reset_n, press, held, enable, tick, rpt.
//  - Top level: slot compare, held/prev registers, L/R conflict logic, event OR.
// TESTING
//  1. Reset: raw=16'h0050 held during Reset_n low -> all outputs 0.
//     Deassert -> keycode=16'h0050, key_held[0]=1 and key_evt[0] pulse, both 1 cycle later.
//  2. Enter in slot1 (raw=16'h2800), gamestate=1 -> key_evt[5] single pulse.
//     Held 100 cycles with 10 frame_ticks -> no further key_evt[5].
//  3. gamestate=2, LEFT held with DAS=16, ARR=6 -> press pulse, first repeat on tick 16,
//     then ticks 22, 28. Release -> no more pulses.
//  4. frame_tick coincident with RIGHT press -> counter = 16, not 15; first repeat on next 16th tick.
//  5. LEFT+RIGHT (raw=16'h4F50) -> two press pulses, zero repeats over 40 ticks.
//     Drop RIGHT -> still no LEFT repeats.
//  6. DOWN repeating in Game, gamestate->3 mid-DAS -> no pulses.
//     Async Reset_n low mid-ARR -> counters 0, key_evt low immediately.

Source files
------------

// File: rtl/key_event_gen_pkg.sv
// Shared key map, gamestate encodings and HID code lookup for the keyboard front end.
package tetris_pkg;

   localparam int NUM_KEYS = 6;

   typedef enum logic [2:0] {
      KEY_LEFT   = 3'd0,
      KEY_RIGHT  = 3'd1,
      KEY_DOWN   = 3'd2,
      KEY_ROTATE = 3'd3,
      KEY_DROP   = 3'd4,
      KEY_ENTER  = 3'd5
   } key_idx_e;

   localparam logic [7:0] HID_LEFT   = 8'h50;
   localparam logic [7:0] HID_RIGHT  = 8'h4F;
   localparam logic [7:0] HID_DOWN   = 8'h51;
   localparam logic [7:0] HID_ROTATE = 8'h52;
   localparam logic [7:0] HID_DROP   = 8'h2C;
   localparam logic [7:0] HID_ENTER  = 8'h28;

   localparam logic [1:0] GS_IDLE = 2'd1;
   localparam logic [1:0] GS_GAME = 2'd2;
   localparam logic [1:0] GS_END  = 2'd3;

   function automatic logic [7:0] hid_code(key_idx_e k);
      logic [7:0] code;
      case (k)
         KEY_LEFT:   code = HID_LEFT;
         KEY_RIGHT:  code = HID_RIGHT;
         KEY_DOWN:   code = HID_DOWN;
         KEY_ROTATE: code = HID_ROTATE;
         KEY_DROP:   code = HID_DROP;
         KEY_ENTER:  code = HID_ENTER;
         default:    code = 8'h00;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Keycode bus between the HID front end (master) and the game logic (slave).
interface key_event_gen_if;
   logic [15:0]                    raw_keycode;
   logic                           frame_tick;
   logic [1:0]                     gamestate;
   logic [15:0]                    keycode;
   logic [tetris_pkg::NUM_KEYS-1:0] key_held;
   logic [tetris_pkg::NUM_KEYS-1:0] key_evt;

   modport master (
      input  raw_keycode, frame_tick, gamestate,
      output keycode, key_held, key_evt
   );

   modport slave (
      output raw_keycode, frame_tick, gamestate,
      input  keycode, key_held, key_evt
   );
endinterface

// File: rtl/key_repeat_ctr.sv
// One delayed-auto-shift counter: loads DAS on press, fires rpt on the tick where it reaches 1.
module key_repeat_ctr #(
   parameter int DAS_FRAMES = 16,
   parameter int ARR_FRAMES = 6
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic press,
   input  logic held,
   input  logic enable,
   input  logic tick,
   output logic rpt
);

   localparam int MAX_FRAMES = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
   localparam int CW         = $clog2(MAX_FRAMES + 1);

   logic [CW-1:0] count_reg;

   // A press cycle only loads; a coincident tick must not count toward DAS.
   assign rpt = held & enable & ~press & tick & (count_reg == CW'(1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count_reg <= '0;
      end else if (!held || !enable) begin
         count_reg <= '0;
      end else if (press) begin
         count_reg <= CW'(DAS_FRAMES);
      end else if (tick && count_reg != '0) begin
         if (count_reg == CW'(1))
            count_reg <= CW'(ARR_FRAMES);
         else
            count_reg <= count_reg - CW'(1);
      end
   end

endmodule

// File: rtl/key_event_gen.sv
// HID report to registered keycode bus plus press/auto-repeat key events.
// Define KEYGEN_SYNC_EN to add a 2-flop register stage on raw_keycode ahead of decode.
module key_event_gen
   import tetris_pkg::*;
#(
   parameter int                  DAS_FRAMES  = 16,
   parameter int                  ARR_FRAMES  = 6,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK = 6'b000111
) (
   input logic             Clk,
   input logic             Reset_n,
   key_event_gen_if.master kif
);

   logic [15:0]         raw_dec;
   logic [15:0]         keycode_reg;
   logic [NUM_KEYS-1:0] held_next;
   logic [NUM_KEYS-1:0] held_reg;
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] rpt;
   logic [NUM_KEYS-1:0] evt_reg;
   logic                game_active;
   logic                lr_conflict;

`ifdef KEYGEN_SYNC_EN
   logic [15:0] raw_s1_reg;
   logic [15:0] raw_s2_reg;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         raw_s1_reg <= '0;
         raw_s2_reg <= '0;
      end else begin
         raw_s1_reg <= kif.raw_keycode;
         raw_s2_reg <= raw_s1_reg;
      end
   end

   assign raw_dec = raw_s2_reg;
`else
   assign raw_dec = kif.raw_keycode;
`endif

   assign game_active = (kif.gamestate == GS_GAME);
   assign press       = held_next & ~held_reg;
   // Opposing directions cancel auto-shift; counters stay at 0 until a fresh press.
   assign lr_conflict = held_next[KEY_LEFT] & held_next[KEY_RIGHT];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         localparam bit IS_LR = (gi == int'(KEY_LEFT)) || (gi == int'(KEY_RIGHT));

         assign held_next[gi] = (raw_dec[7:0]  == hid_code(key_idx_e'(gi))) |
                                (raw_dec[15:8] == hid_code(key_idx_e'(gi)));

         if (REPEAT_MASK[gi]) begin : g_rep
            key_repeat_ctr #(
               .DAS_FRAMES (DAS_FRAMES),
               .ARR_FRAMES (ARR_FRAMES)
            ) u_ctr (
               .Clk     (Clk),
               .Reset_n (Reset_n),
               .press   (press[gi]),
               .held    (held_next[gi]),
               .enable  (game_active & ~(IS_LR & lr_conflict)),
               .tick    (kif.frame_tick),
               .rpt     (rpt[gi])
            );
         end else begin : g_norep
            assign rpt[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         keycode_reg <= '0;
         held_reg    <= '0;
         evt_reg     <= '0;
      end else begin
         keycode_reg <= raw_dec;
         held_reg    <= held_next;
         evt_reg     <= press | rpt;
      end
   end

   assign kif.keycode  = keycode_reg;
   assign kif.key_held = held_reg;
   assign kif.key_evt  = evt_reg;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed self-checking bench for key_event_gen (default build, DAS=16, ARR=6).
module tb_key_event_gen;
   import tetris_pkg::*;

   logic Clk;
   logic Reset_n;

   key_event_gen_if kif ();

   key_event_gen dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .kif     (kif)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int evt_total [NUM_KEYS];
   int hit_cnt;
   int hit_idx [4];
   int base;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance one clock and sample just after the edge; tallies every event pulse seen.
   task automatic step();
      @(posedge Clk);
      #1;
      for (int k = 0; k < NUM_KEYS; k++)
         if (kif.key_evt[k] === 1'b1) evt_total[k]++;
   endtask

   // n frame ticks, each followed by one idle cycle; records which ticks fired key k.
   task automatic run_ticks(input int n, input int k);
      hit_cnt = 0;
      for (int i = 0; i < 4; i++) hit_idx[i] = 0;
      for (int t = 1; t <= n; t++) begin
         kif.frame_tick = 1'b1;
         step();
         if (kif.key_evt[k] === 1'b1) begin
            if (hit_cnt < 4) hit_idx[hit_cnt] = t;
            hit_cnt++;
         end
         kif.frame_tick = 1'b0;
         step();
      end
   endtask

   initial begin
      for (int k = 0; k < NUM_KEYS; k++) evt_total[k] = 0;
      Reset_n         = 1'b0;
      kif.raw_keycode = 16'h0050;
      kif.frame_tick  = 1'b0;
      kif.gamestate   = GS_IDLE;

      // 1. reset with LEFT held, then release reset
      repeat (3) step();
      check("rst_keycode", 32'(kif.keycode), 32'h0);
      check("rst_held", 32'(kif.key_held), 32'h0);
      check("rst_evt", 32'(kif.key_evt), 32'h0);
      Reset_n = 1'b1;
      #1;
      check("deassert_evt_same_cycle", 32'(kif.key_evt), 32'h0);
      step();
      check("post_rst_keycode", 32'(kif.keycode), 32'h0050);
      check("post_rst_held", 32'(kif.key_held), 32'h01);
      check("post_rst_evt", 32'(kif.key_evt), 32'h01);
      step();
      check("post_rst_evt_1cyc", 32'(kif.key_evt), 32'h0);
      check("post_rst_held_stays", 32'(kif.key_held), 32'h01);

      // 2. ENTER in slot1 while idle: one press, no repeats
      kif.raw_keycode = 16'h0000;
      step();
      check("release_no_evt", 32'(kif.key_evt), 32'h0);
      check("release_held", 32'(kif.key_held), 32'h0);
      kif.raw_keycode = 16'h2800;
      step();
      check("enter_keycode", 32'(kif.keycode), 32'h2800);
      check("enter_press_evt", 32'(kif.key_evt), 32'h20);
      check("enter_held", 32'(kif.key_held), 32'h20);
      base = evt_total[KEY_ENTER];
      for (int i = 0; i < 10; i++) begin
         kif.frame_tick = 1'b1;
         step();
         kif.frame_tick = 1'b0;
         repeat (9) step();
      end
      check("enter_no_repeat", 32'(evt_total[KEY_ENTER] - base), 32'd0);

      // 3. LEFT in Game: repeats on ticks 16, 22, 28
      kif.raw_keycode = 16'h0000;
      step();
      kif.gamestate   = GS_GAME;
      base            = evt_total[KEY_LEFT];
      kif.raw_keycode = 16'h0050;
      step();
      check("left_press_evt", 32'(kif.key_evt), 32'h01);
      run_ticks(30, KEY_LEFT);
      check("left_rpt_count", 32'(hit_cnt), 32'd3);
      check("left_rpt1_tick", 32'(hit_idx[0]), 32'd16);
      check("left_rpt2_tick", 32'(hit_idx[1]), 32'd22);
      check("left_rpt3_tick", 32'(hit_idx[2]), 32'd28);
      check("left_total_pulses", 32'(evt_total[KEY_LEFT] - base), 32'd4);
      kif.raw_keycode = 16'h0000;
      step();
      check("left_release_held", 32'(kif.key_held), 32'h0);
      base = evt_total[KEY_LEFT];
      run_ticks(20, KEY_LEFT);
      check("left_after_release", 32'(evt_total[KEY_LEFT] - base), 32'd0);

      // 4. RIGHT pressed on a frame_tick: that tick does not count
      kif.raw_keycode = 16'h004F;
      kif.frame_tick  = 1'b1;
      step();
      check("right_press_evt", 32'(kif.key_evt), 32'h02);
      kif.frame_tick = 1'b0;
      step();
      run_ticks(20, KEY_RIGHT);
      check("right_rpt_count", 32'(hit_cnt), 32'd1);
      check("right_first_rpt_tick", 32'(hit_idx[0]), 32'd16);
      kif.raw_keycode = 16'h0000;
      step();

      // 5. LEFT+RIGHT together: presses but no repeats, even after dropping RIGHT
      kif.raw_keycode = 16'h4F50;
      step();
      check("lr_press_evt", 32'(kif.key_evt), 32'h03);
      base = evt_total[KEY_LEFT] + evt_total[KEY_RIGHT];
      run_ticks(40, KEY_LEFT);
      check("lr_no_repeat", 32'(evt_total[KEY_LEFT] + evt_total[KEY_RIGHT] - base), 32'd0);
      kif.raw_keycode = 16'h0050;
      step();
      check("drop_right_evt", 32'(kif.key_evt), 32'h0);
      check("drop_right_held", 32'(kif.key_held), 32'h01);
      base = evt_total[KEY_LEFT];
      run_ticks(40, KEY_LEFT);
      check("left_no_resume", 32'(evt_total[KEY_LEFT] - base), 32'd0);
      kif.raw_keycode = 16'h0000;
      step();

      // 6. DOWN: leave Game mid-DAS, re-enter, then reset mid-ARR
      kif.raw_keycode = 16'h0051;
      step();
      check("down_press_evt", 32'(kif.key_evt), 32'h04);
      base = evt_total[KEY_DOWN];
      run_ticks(8, KEY_DOWN);
      kif.gamestate = GS_END;
      run_ticks(30, KEY_DOWN);
      check("down_end_no_rpt", 32'(evt_total[KEY_DOWN] - base), 32'd0);
      kif.gamestate = GS_GAME;
      run_ticks(30, KEY_DOWN);
      check("down_reenter_no_rpt", 32'(evt_total[KEY_DOWN] - base), 32'd0);
      kif.raw_keycode = 16'h0000;
      step();
      kif.raw_keycode = 16'h0051;
      step();
      check("down_repress_evt", 32'(kif.key_evt), 32'h04);
      run_ticks(21, KEY_DOWN);
      check("down_rpt_count", 32'(hit_cnt), 32'd1);
      check("down_rpt_tick", 32'(hit_idx[0]), 32'd16);
      kif.frame_tick = 1'b1;
      step();
      check("down_arr_pulse", 32'(kif.key_evt), 32'h04);
      kif.frame_tick = 1'b0;
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_rst_evt", 32'(kif.key_evt), 32'h0);
      check("async_rst_held", 32'(kif.key_held), 32'h0);
      check("async_rst_keycode", 32'(kif.keycode), 32'h0);
      repeat (2) step();
      check("rst_hold_evt", 32'(kif.key_evt), 32'h0);
      Reset_n = 1'b1;
      step();
      check("rst_release_press", 32'(kif.key_evt), 32'h04);
      run_ticks(16, KEY_DOWN);
      check("post_rst_das_count", 32'(hit_cnt), 32'd1);
      check("post_rst_das_tick", 32'(hit_idx[0]), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
